// File: rtl/gpu_pkg.sv
// Shared GPU types for the warp dispatch path.
//   warp_reg_t       : 8-bit warp descriptor carried through the ready queue
//   dispatch_state_e : dispatcher FSM states
//   MAX_CORES        : upper bound on cores a dispatcher may serve
package gpu_pkg;

    localparam int unsigned MAX_CORES = 8;

    typedef logic [7:0] warp_reg_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        LATCH,
        ISSUE
    } dispatch_state_e;

endpackage

// File: rtl/warp_dispatcher_if.sv
// Bus between the warp dispatcher and the circular_buffer ready queue.
//   buf_empty, buf_overflow, buf_data : buffer status / data_out
//   buf_read, buf_pop, buf_push       : read_buffer / pop_buffer / push_buffer strobes
//   buf_push_data                     : data_in
// master = dispatcher side, slave = buffer side.
interface warp_dispatcher_if
    import gpu_pkg::*;
#(
    parameter type T = warp_reg_t
);
    logic buf_empty;
    logic buf_overflow;
    T     buf_data;
    logic buf_read;
    logic buf_pop;
    logic buf_push;
    T     buf_push_data;

    modport master (
        input  buf_empty,
        input  buf_overflow,
        input  buf_data,
        output buf_read,
        output buf_pop,
        output buf_push,
        output buf_push_data
    );

    modport slave (
        output buf_empty,
        output buf_overflow,
        output buf_data,
        input  buf_read,
        input  buf_pop,
        input  buf_push,
        input  buf_push_data
    );
endinterface

// File: rtl/prio_arbiter.sv
// Combinational fixed-priority arbiter: lowest set request index wins.
//   req       : request vector
//   grant     : one-hot grant (all zero when no request)
//   any_valid : at least one request asserted
module prio_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic         any_valid
);
    // Two's-complement trick isolates the lowest set bit.
    assign grant     = req & (~req + N'(1));
    assign any_valid = |req;
endmodule

// File: rtl/warp_dispatcher.sv
// Warp dispatcher: drains the ready queue head and issues each warp to the
// lowest-indexed idle core, and pushes yielded warps back onto the queue tail.
//   clk, rst          : clock, asynchronous active-low reset
//   enable            : allow new fetches (an in-flight warp is always finished)
//   bus               : ready-queue bus (master side)
//   core_idle         : per-core idle flags
//   dispatch_valid    : one-hot, one-cycle issue pulse
//   dispatch_warp     : warp issued with dispatch_valid
//   core_yield        : per-core yield request, held until yield_ack
//   core_yield_warp   : per-core yielded warp, core 0 in LSBs
//   yield_ack         : one-hot, one-cycle yield acceptance
//   dispatched_cnt    : total warps issued, wrapping
//   error             : sticky buffer-overflow flag
// NUM_CORES must lie in 1..MAX_CORES.
module warp_dispatcher
    import gpu_pkg::*;
#(
    parameter int unsigned NUM_CORES = 4,
    parameter type         T         = warp_reg_t,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    warp_dispatcher_if.master             bus,
    input  logic [NUM_CORES-1:0]          core_idle,
    output logic [NUM_CORES-1:0]          dispatch_valid,
    output T                              dispatch_warp,
    input  logic [NUM_CORES-1:0]          core_yield,
    input  logic [NUM_CORES*$bits(T)-1:0] core_yield_warp,
    output logic [NUM_CORES-1:0]          yield_ack,
    output logic [CNT_W-1:0]              dispatched_cnt,
    output logic                          error
);
    localparam int unsigned TW = $bits(T);

    dispatch_state_e state_q, state_d;
    T                warp_q;
    logic            read_s, pop_s, issue_s;

    logic [NUM_CORES-1:0] dispatch_valid_q;
    T                     dispatch_warp_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [NUM_CORES-1:0] yield_ack_q;
    logic                 push_q;
    T                     push_data_q;
    logic                 error_q;

    logic [NUM_CORES-1:0] idle_grant, yield_req, yield_grant;
    logic                 idle_any, yield_any;
    T                     yield_warp;

    prio_arbiter #(.N(NUM_CORES)) u_idle_arb (
        .req       (core_idle),
        .grant     (idle_grant),
        .any_valid (idle_any)
    );

    // A core still shows core_yield in the cycle its ack is visible; masking
    // with the current ack stops the same warp being accepted twice.
    assign yield_req = core_yield & ~yield_ack_q;

    prio_arbiter #(.N(NUM_CORES)) u_yield_arb (
        .req       (yield_req),
        .grant     (yield_grant),
        .any_valid (yield_any)
    );

    always_comb begin
        yield_warp = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (yield_grant[i]) begin
                yield_warp = core_yield_warp[i*TW +: TW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        read_s  = 1'b0;
        pop_s   = 1'b0;
        issue_s = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable && !bus.buf_empty) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                read_s  = 1'b1;
                state_d = LATCH;
            end
            LATCH: begin
                pop_s   = 1'b1;
                state_d = ISSUE;
            end
            ISSUE: begin
                // enable is deliberately ignored here: a latched warp is never dropped.
                if (idle_any) begin
                    issue_s = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= IDLE;
            warp_q           <= '0;
            dispatch_valid_q <= '0;
            dispatch_warp_q  <= '0;
            cnt_q            <= '0;
            yield_ack_q      <= '0;
            push_q           <= 1'b0;
            push_data_q      <= '0;
            error_q          <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == LATCH) begin
                warp_q <= bus.buf_data;
            end
            dispatch_valid_q <= issue_s ? idle_grant : '0;
            if (issue_s) begin
                dispatch_warp_q <= warp_q;
                cnt_q           <= cnt_q + CNT_W'(1);
            end
            yield_ack_q <= yield_grant;
            push_q      <= yield_any;
            if (yield_any) begin
                push_data_q <= yield_warp;
            end
            if (bus.buf_overflow) begin
                error_q <= 1'b1;
            end
        end
    end

    assign bus.buf_read      = read_s;
    assign bus.buf_pop       = pop_s;
    assign bus.buf_push      = push_q;
    assign bus.buf_push_data = push_data_q;
    assign dispatch_valid    = dispatch_valid_q;
    assign dispatch_warp     = dispatch_warp_q;
    assign yield_ack         = yield_ack_q;
    assign dispatched_cnt    = cnt_q;
    assign error             = error_q;
endmodule
